sd_block_read_controller: RTL and testbench
===========================================

Name: sd_block_read_controller

Overview:
- Sequences one SPI single-block read (CMD17) from an SD card that has already been initialised.
- Operates after the card initialiser reports card_ready. Shares SCLK = d_clock with the SPI bus.
- Drives CS/MOSI, samples MISO, and streams the 512 data bytes into the downstream byte FIFO via fifo_data_in/fifo_push.
- Reports done or error to the top-level state machine.

Parameters:
- BLOCK_BYTES, 512: data bytes per block.
- R1_TIMEOUT, 8: maximum response bytes scanned for R1.
- TOKEN_TIMEOUT, 1024: maximum bytes scanned for the 0xFE start token.
- BYTE_ADDR, 1: 1 means the argument is block_addr<<9 (SDSC byte addressing); 0 means block_addr as-is (SDHC).

Ports:
- d_clock  in  1  system/SPI clock; also drives SCLK externally
- reset_PB_down  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE with card_ready=1
- block_addr  in  32  block number; sampled on the accepted start
- card_ready  in  1  initialiser complete
- MISO  in  1  card data out
- CS  out  1  chip select, active-low
- MOSI  out  1  host data to card
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  one-cycle pulse on abort
- err_code  out  2  held until next accepted start: 0 none, 1 R1 timeout or R1!=0x00, 2 token timeout or bad token, 3 FIFO overflow
- fifo_data_in  out  8  assembled data byte
- fifo_push  out  1  one-cycle write strobe
- fifo_full  in  1  downstream FIFO full

Behaviour:
- Clock and reset: clock is d_clock; reset reset_PB_down is asynchronous, active-high.
- Timing:
  - All control state updates on posedge d_clock.
  - MISO is sampled on posedge.
  - MOSI comes from a register loaded on negedge d_clock with the bit chosen by the posedge state (SPI mode 0).
- Reset values: state=IDLE, CS=1, MOSI=1, busy=0, done=0, error=0, err_code=0, fifo_push=0, fifo_data_in=0x00, all counters 0.
- Byte engine:
  - 3-bit bit counter, MSB first.
  - A byte is complete on the posedge where bit counter = 7; the counter then wraps to 0.
- States:
  - IDLE: CS=1, MOSI=1. On start && card_ready, latch the argument and go to PRE. A start while card_ready=0 is ignored.
  - PRE: CS=0, MOSI=1 for 8 clocks, then SEND_CMD.
  - SEND_CMD: shift 48 bits: 0x51, 32-bit argument MSB first, 0xFF. After bit 47, go to WAIT_R1.
  - WAIT_R1: MOSI=1.
    - Per completed byte: 0xFF increments the timeout count. 0x00 goes to WAIT_TOKEN. Any other value aborts with code 1.
    - R1_TIMEOUT bytes of 0xFF also abort with code 1.
  - WAIT_TOKEN: per completed byte: 0xFE goes to READ_DATA. 0xFF counts toward the timeout. Any other value, or TOKEN_TIMEOUT bytes of 0xFF, aborts with code 2.
  - READ_DATA:
    - Each completed byte: fifo_data_in=byte and fifo_push=1 for exactly that cycle. The 10-bit byte counter increments.
    - If fifo_full=1 on the completing cycle, no push occurs and the block aborts with code 3. The SPI clock cannot stall.
    - After BLOCK_BYTES bytes, go to READ_CRC.
  - READ_CRC: 2 bytes, discarded (no CRC check), then FINISH.
  - FINISH: CS=1, MOSI=1 for 8 clocks. Then return to IDLE with done pulsed on the same edge.
  - ABORT path: go to FINISH with an error flag. On exit to IDLE, error is pulsed instead of done, and err_code is set.
- Pulses: done and error never assert together. fifo_push never asserts outside READ_DATA.
- Other inputs:
  - start during busy is ignored.
  - card_ready falling mid-transfer is ignored; the transfer completes normally.
- Reset mid-operation: CS=1 and all outputs return to reset values immediately (asynchronously). No partial push and no done/error pulse occur.
- Latency, start to first fifo_push: 1 + 8 + 48 + 8·(R1 bytes) + 8·(token-wait bytes incl. token) + 8 clocks.

Decomposition:
- Shared package:
  - state encodings (5-bit, IDLE=0)
  - CMD17 opcode 0x51, DATA_TOKEN 0xFE, dummy CRC 0xFF
  - err_code constants
  - BLOCK_BYTES default
- One sub-module: sd_spi_byte_shifter.
  - Negedge MOSI register, posedge MISO shift register, bit counter.
  - byte_done strobe and tx/rx byte ports.
  - The controller FSM and counters remain in sd_block_read_controller.

Test Plan:
- Card model returns R1=0x00 after 2×0xFF, token 0xFE after 5×0xFF, data bytes i mod 256, block_addr=3, BYTE_ADDR=1:
  - MOSI carries 0x51, 0x00000600, 0xFF.
  - Exactly 512 fifo_push pulses with bytes 0x00..0xFF twice.
  - done pulses once; err_code=0; CS high after 8 trailing clocks.
- Card holds MISO=1: after 8 bytes in WAIT_R1, error pulses with err_code=1. No fifo_push, and CS returns high.
- R1=0x05: immediate abort, err_code=1. Token 0xFC instead of 0xFE: err_code=2, no pushes.
- fifo_full asserted at byte 100: exactly 100 pushes, then err_code=3 and error pulse. The next start clears err_code to 0.
- reset_PB_down asserted mid-READ_DATA (byte 200): CS=1, MOSI=1, busy=0 immediately. No done/error pulse. A following start works normally.
- start pulsed with card_ready=0, and start pulsed while busy: both ignored, with no state change and no second transfer.

Source files
------------

// File: rtl/sd_block_read_controller_pkg.sv
// Shared constants for the SD CMD17 single-block read path: FSM encodings,
// command/token bytes and abort codes.
package sd_block_read_controller_pkg;

  localparam logic [4:0] S_IDLE       = 5'd0;
  localparam logic [4:0] S_PRE        = 5'd1;
  localparam logic [4:0] S_SEND_CMD   = 5'd2;
  localparam logic [4:0] S_WAIT_R1    = 5'd3;
  localparam logic [4:0] S_WAIT_TOKEN = 5'd4;
  localparam logic [4:0] S_READ_DATA  = 5'd5;
  localparam logic [4:0] S_READ_CRC   = 5'd6;
  localparam logic [4:0] S_FINISH     = 5'd7;

  localparam logic [7:0] CMD17_OP   = 8'h51;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] DUMMY_CRC  = 8'hFF;
  localparam logic [7:0] R1_READY   = 8'h00;
  localparam logic [7:0] IDLE_BYTE  = 8'hFF;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_R1       = 2'd1;
  localparam logic [1:0] ERR_TOKEN    = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  localparam int BLOCK_BYTES_DEF = 512;

  // SDSC cards take a byte address, SDHC cards take the block number directly.
  function automatic logic [31:0] cmd17_arg(input logic [31:0] blk, input logic byte_addr);
    return byte_addr ? {blk[22:0], 9'd0} : blk;
  endfunction

endpackage

// File: rtl/sd_spi_byte_shifter.sv
// SPI mode-0 byte engine: MOSI launched on negedge, MISO sampled on posedge,
// MSB first, with a strobe on the posedge that completes each byte.
module sd_spi_byte_shifter (
  input  logic       d_clock,
  input  logic       reset_PB_down,
  input  logic       active,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       mosi,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic       mosi_q, mosi_d;

  always_comb begin
    bit_cnt_d = active ? bit_cnt_q + 3'd1 : 3'd0;
    rx_d      = active ? {rx_q[5:0], miso} : rx_q;
    mosi_d    = active ? tx_byte[~bit_cnt_q] : 1'b1;
  end

  always_ff @(posedge d_clock or posedge reset_PB_down) begin
    if (reset_PB_down) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
    end
  end

  // The bit index seen here was settled by the preceding posedge.
  always_ff @(negedge d_clock or posedge reset_PB_down) begin
    if (reset_PB_down) mosi_q <= 1'b1;
    else               mosi_q <= mosi_d;
  end

  assign mosi      = mosi_q;
  assign byte_done = active && (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_q, miso};

endmodule

// File: rtl/sd_block_read_controller.sv
// CMD17 single-block read sequencer: issues the command, scans for R1 and the
// start token, and streams the data bytes into the downstream FIFO.
module sd_block_read_controller
  import sd_block_read_controller_pkg::*;
#(
  parameter int BLOCK_BYTES   = BLOCK_BYTES_DEF,
  parameter int R1_TIMEOUT    = 8,
  parameter int TOKEN_TIMEOUT = 1024,
  parameter int BYTE_ADDR     = 1
) (
  input  logic        d_clock,
  input  logic        reset_PB_down,
  input  logic        start,
  input  logic [31:0] block_addr,
  input  logic        card_ready,
  input  logic        MISO,
  output logic        CS,
  output logic        MOSI,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  fifo_data_in,
  output logic        fifo_push,
  input  logic        fifo_full
);

  logic [4:0]  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] arg_q, arg_d;
  logic [1:0]  err_pend_q, err_pend_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        done_q, done_d, error_q, error_d, push_q, push_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  tx_byte, rx_byte;
  logic        byte_done;

  sd_spi_byte_shifter u_shifter (
    .d_clock       (d_clock),
    .reset_PB_down (reset_PB_down),
    .active        (state_q != S_IDLE),
    .tx_byte       (tx_byte),
    .miso          (MISO),
    .mosi          (MOSI),
    .byte_done     (byte_done),
    .rx_byte       (rx_byte)
  );

  // Only the command phase drives anything but all-ones onto MOSI.
  always_comb begin
    tx_byte = IDLE_BYTE;
    if (state_q == S_SEND_CMD) begin
      case (cnt_q[2:0])
        3'd0:    tx_byte = CMD17_OP;
        3'd1:    tx_byte = arg_q[31:24];
        3'd2:    tx_byte = arg_q[23:16];
        3'd3:    tx_byte = arg_q[15:8];
        3'd4:    tx_byte = arg_q[7:0];
        default: tx_byte = DUMMY_CRC;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arg_d      = arg_q;
    err_pend_d = err_pend_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    push_d     = 1'b0;
    data_d     = data_q;
    case (state_q)
      S_IDLE: if (start && card_ready) begin
        arg_d      = cmd17_arg(block_addr, BYTE_ADDR != 0);
        err_code_d = ERR_NONE;
        err_pend_d = ERR_NONE;
        cnt_d      = '0;
        state_d    = S_PRE;
      end
      S_PRE: if (byte_done) state_d = S_SEND_CMD;
      S_SEND_CMD: if (byte_done) begin
        if (cnt_q == 10'd5) begin
          cnt_d   = '0;
          state_d = S_WAIT_R1;
        end else cnt_d = cnt_q + 10'd1;
      end
      S_WAIT_R1: if (byte_done) begin
        if (rx_byte == R1_READY) begin
          cnt_d   = '0;
          state_d = S_WAIT_TOKEN;
        end else if (rx_byte == IDLE_BYTE && cnt_q != 10'(R1_TIMEOUT - 1)) begin
          cnt_d = cnt_q + 10'd1;
        end else begin
          cnt_d      = '0;
          err_pend_d = ERR_R1;
          state_d    = S_FINISH;
        end
      end
      S_WAIT_TOKEN: if (byte_done) begin
        if (rx_byte == DATA_TOKEN) begin
          cnt_d   = '0;
          state_d = S_READ_DATA;
        end else if (rx_byte == IDLE_BYTE && cnt_q != 10'(TOKEN_TIMEOUT - 1)) begin
          cnt_d = cnt_q + 10'd1;
        end else begin
          cnt_d      = '0;
          err_pend_d = ERR_TOKEN;
          state_d    = S_FINISH;
        end
      end
      // The card keeps clocking out data, so a full FIFO can only abort.
      S_READ_DATA: if (byte_done) begin
        if (fifo_full) begin
          cnt_d      = '0;
          err_pend_d = ERR_OVERFLOW;
          state_d    = S_FINISH;
        end else begin
          push_d = 1'b1;
          data_d = rx_byte;
          if (cnt_q == 10'(BLOCK_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_READ_CRC;
          end else cnt_d = cnt_q + 10'd1;
        end
      end
      S_READ_CRC: if (byte_done) begin
        if (cnt_q == 10'd1) begin
          cnt_d   = '0;
          state_d = S_FINISH;
        end else cnt_d = cnt_q + 10'd1;
      end
      S_FINISH: if (byte_done) begin
        state_d = S_IDLE;
        if (err_pend_q != ERR_NONE) begin
          error_d    = 1'b1;
          err_code_d = err_pend_q;
        end else done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge d_clock or posedge reset_PB_down) begin
    if (reset_PB_down) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      arg_q      <= '0;
      err_pend_q <= ERR_NONE;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      push_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arg_q      <= arg_d;
      err_pend_q <= err_pend_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      error_q    <= error_d;
      push_q     <= push_d;
      data_q     <= data_d;
    end
  end

  assign CS           = (state_q == S_IDLE) || (state_q == S_FINISH);
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign fifo_push    = push_q;
  assign fifo_data_in = data_q;

endmodule

// File: tb/tb_sd_block_read_controller.sv
// Bench for sd_block_read_controller: an SD card model answers CMD17 from a
// per-vector byte stream; pushes are checked against an expected queue.
module tb_sd_block_read_controller;

  logic        d_clock = 1'b0;
  logic        reset_PB_down, start, card_ready, MISO, fifo_full;
  logic [31:0] block_addr;
  logic        CS, MOSI, busy, done, error, fifo_push;
  logic [1:0]  err_code;
  logic [7:0]  fifo_data_in;

  sd_block_read_controller dut (
    .d_clock       (d_clock),
    .reset_PB_down (reset_PB_down),
    .start         (start),
    .block_addr    (block_addr),
    .card_ready    (card_ready),
    .MISO          (MISO),
    .CS            (CS),
    .MOSI          (MOSI),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .fifo_data_in  (fifo_data_in),
    .fifo_push     (fifo_push),
    .fifo_full     (fifo_full)
  );

  always #5 d_clock = ~d_clock;

  typedef struct {
    int          r1_ff;
    logic [7:0]  r1_val;
    int          tok_ff;
    logic [7:0]  tok_val;
    int          full_at;
    logic [31:0] addr;
    bit          rnd_data;
    logic [1:0]  exp_code;
    int          exp_pushes;
  } vec_t;

  localparam int NEVER = 100000;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int push_cnt, done_cnt, error_cnt, both_cnt, first_push_cyc, cur_full_at;
  logic [7:0] exp_q[$];
  logic [7:0] resp[$];
  int pos_bits = 0;
  int rd_bit = 0;
  logic [55:0] cmd_sr = '0;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge d_clock) cyc <= cyc + 1;

  // Card side: count host bits while selected, capture PRE + command.
  always @(posedge d_clock) begin
    if (CS) pos_bits <= 0;
    else begin
      if (pos_bits < 56) cmd_sr <= {cmd_sr[54:0], MOSI};
      pos_bits <= pos_bits + 1;
    end
  end

  // Card answers after the 56 host bits, changing MISO on the falling edge.
  always @(negedge d_clock) begin
    if (CS) begin
      MISO = 1'b1;
      rd_bit = 0;
    end else if (pos_bits >= 56) begin
      if (rd_bit / 8 < resp.size()) MISO = resp[rd_bit / 8][7 - (rd_bit % 8)];
      else MISO = 1'b1;
      rd_bit++;
    end
  end

  always @(negedge d_clock) begin
    if (fifo_push) begin
      push_cnt++;
      if (first_push_cyc < 0) first_push_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_push: got byte %0h, required no push", fifo_data_in);
      end else check("push_data", fifo_data_in, exp_q.pop_front());
      if (push_cnt >= cur_full_at) fifo_full = 1'b1;
    end
    if (done) done_cnt++;
    if (error) error_cnt++;
    if (done && error) both_cnt++;
  end

  // Reference: outcome from the card's answer rules, not from FSM internals.
  task automatic model(inout vec_t v);
    if (v.r1_ff >= 8 || v.r1_val != 8'h00) begin
      v.exp_code = 2'd1; v.exp_pushes = 0;
    end else if (v.tok_ff >= 1024 || v.tok_val != 8'hFE) begin
      v.exp_code = 2'd2; v.exp_pushes = 0;
    end else if (v.full_at < 512) begin
      v.exp_code = 2'd3; v.exp_pushes = v.full_at;
    end else begin
      v.exp_code = 2'd0; v.exp_pushes = 512;
    end
  endtask

  task automatic launch(input vec_t v, output int s);
    logic [7:0] b;
    resp.delete();
    exp_q.delete();
    repeat (v.r1_ff) resp.push_back(8'hFF);
    resp.push_back(v.r1_val);
    repeat (v.tok_ff) resp.push_back(8'hFF);
    resp.push_back(v.tok_val);
    for (int i = 0; i < 512; i++) begin
      b = v.rnd_data ? 8'($urandom_range(0, 255)) : 8'(i);
      resp.push_back(b);
      if (i < v.exp_pushes) exp_q.push_back(b);
    end
    resp.push_back(8'($urandom_range(0, 255)));
    resp.push_back(8'($urandom_range(0, 255)));
    push_cnt = 0; done_cnt = 0; error_cnt = 0; both_cnt = 0; first_push_cyc = -1;
    cur_full_at = v.full_at;
    fifo_full = (v.full_at == 0);
    @(negedge d_clock);
    block_addr = v.addr;
    card_ready = 1'b1;
    start = 1'b1;
    s = cyc;
    @(negedge d_clock);
    start = 1'b0;
    block_addr = $urandom;
    check("busy_after_start", busy, 1);
    check("err_code_cleared", err_code, 0);
  endtask

  task automatic finish_vec(input vec_t v, input int s);
    logic [31:0] a;
    int k;
    for (k = 0; k < 20000 && (done_cnt + error_cnt) == 0; k++) @(negedge d_clock);
    check("completed_in_budget", (done_cnt + error_cnt) != 0, 1);
    a = v.addr * 32'd512;
    check("pre_and_cmd17", cmd_sr, {8'hFF, 8'h51, a, 8'hFF});
    check("push_count", push_cnt, v.exp_pushes);
    check("pushes_outstanding", exp_q.size(), 0);
    check("done_pulses", done_cnt, (v.exp_code == 2'd0) ? 1 : 0);
    check("error_pulses", error_cnt, (v.exp_code != 2'd0) ? 1 : 0);
    check("err_code", err_code, v.exp_code);
    check("cs_after", CS, 1);
    check("busy_after", busy, 0);
    check("mosi_after", MOSI, 1);
    check("done_error_overlap", both_cnt, 0);
    if (v.exp_code == 2'd0)
      check("first_push_latency", first_push_cyc - s,
            1 + 8 + 48 + 8 * (v.r1_ff + 1) + 8 * (v.tok_ff + 1) + 8);
    repeat (30) @(negedge d_clock);
    check("no_extra_pulses", done_cnt + error_cnt, 1);
    check("stays_idle", busy, 0);
  endtask

  initial begin
    int s, k;
    vec_t v;
    //          r1_ff r1    tok_ff tok    full_at addr          rnd code pushes
    vecs[0]  = '{2,   8'h00, 5,    8'hFE, NEVER,  32'd3,        0,  2'd0, 512};
    vecs[1]  = '{8,   8'h00, 0,    8'hFE, NEVER,  32'd7,        0,  2'd1, 0};
    vecs[2]  = '{0,   8'h05, 0,    8'hFE, NEVER,  32'd9,        0,  2'd1, 0};
    vecs[3]  = '{1,   8'h00, 2,    8'hFC, NEVER,  32'd11,       0,  2'd2, 0};
    vecs[4]  = '{2,   8'h00, 5,    8'hFE, 100,    32'd3,        0,  2'd3, 100};
    vecs[5]  = '{7,   8'h00, 0,    8'hFE, NEVER,  32'h12345,    1,  2'd0, 512};
    vecs[6]  = '{0,   8'h00, 1023, 8'hFE, NEVER,  32'h00ABCDEF, 1,  2'd0, 512};
    vecs[7]  = '{0,   8'h00, 1024, 8'hFE, NEVER,  32'd1,        0,  2'd2, 0};
    vecs[8]  = '{1,   8'h00, 1,    8'hFE, 0,      32'd2,        0,  2'd3, 0};
    vecs[9]  = '{1,   8'h00, 1,    8'hFE, 511,    32'd5,        1,  2'd3, 511};
    for (int i = 10; i < 13; i++) begin
      v.r1_ff    = $urandom_range(0, 9);
      v.r1_val   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 254)) : 8'h00;
      v.tok_ff   = $urandom_range(0, 20);
      v.tok_val  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 253)) : 8'hFE;
      v.full_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 511) : NEVER;
      v.addr     = $urandom;
      v.rnd_data = 1;
      model(v);
      vecs[i] = v;
    end

    reset_PB_down = 1'b0;
    start = 1'b0; card_ready = 1'b0; fifo_full = 1'b0; block_addr = '0; MISO = 1'b1;
    cur_full_at = NEVER; push_cnt = 0; done_cnt = 0; error_cnt = 0; both_cnt = 0; first_push_cyc = -1;
    #1 reset_PB_down = 1'b1;
    repeat (3) @(negedge d_clock);
    check("rst_cs", CS, 1);
    check("rst_mosi", MOSI, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_push", fifo_push, 0);
    check("rst_data", fifo_data_in, 0);
    reset_PB_down = 1'b0;
    repeat (2) @(negedge d_clock);

    // start without card_ready must be ignored
    start = 1'b1; block_addr = 32'd3;
    @(negedge d_clock);
    start = 1'b0;
    check("not_ready_busy", busy, 0);
    repeat (20) @(negedge d_clock);
    check("not_ready_cs", CS, 1);
    check("not_ready_pulses", done_cnt + error_cnt + push_cnt, 0);

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i], s);
      finish_vec(vecs[i], s);
    end

    // asynchronous reset while streaming data byte 200
    launch(vecs[0], s);
    for (k = 0; k < 20000 && push_cnt < 200; k++) @(negedge d_clock);
    check("reached_byte_200", push_cnt >= 200, 1);
    #2 reset_PB_down = 1'b1;
    #1;
    check("midrst_cs", CS, 1);
    check("midrst_mosi", MOSI, 1);
    check("midrst_busy", busy, 0);
    check("midrst_push", fifo_push, 0);
    check("midrst_data", fifo_data_in, 0);
    repeat (3) @(negedge d_clock);
    reset_PB_down = 1'b0;
    repeat (10) @(negedge d_clock);
    check("midrst_push_count", push_cnt, 200);
    check("midrst_pulses", done_cnt + error_cnt, 0);
    exp_q.delete();

    // normal transfer after reset, with a start while busy and card_ready dropping
    launch(vecs[0], s);
    repeat (18) @(negedge d_clock);
    start = 1'b1; block_addr = 32'hDEAD;
    @(negedge d_clock);
    start = 1'b0;
    repeat (10) @(negedge d_clock);
    card_ready = 1'b0;
    finish_vec(vecs[0], s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
